// File: rtl/rcv_pkg.sv
// rcv_pkg: shared types, frame-size constants and helpers for the receiver.
// Used by rcv_ctrl and flex_counter.
package rcv_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    RECV     = 3'd2,
    STOP_CHK = 3'd3,
    LOAD     = 3'd4
  } rcv_state_t;

  localparam logic [3:0] DSIZE_5 = 4'd5;
  localparam logic [3:0] DSIZE_7 = 4'd7;
  localparam logic [3:0] DSIZE_8 = 4'd8;

  function automatic logic [3:0] fix_dsize(
    input logic [3:0] d
  );
    unique case (d)
      DSIZE_5, DSIZE_7, DSIZE_8: return d;
      default:                   return DSIZE_8;
    endcase
  endfunction

  function automatic logic maj3(
    input logic [2:0] s
  );
    return (s[0] & s[1]) |
           (s[1] & s[2]) |
           (s[0] & s[2]);
  endfunction

endpackage

// File: rtl/rcv_flex_counter.sv
// flex_counter: up-counter that wraps from rollover_val back to 1.
// rollover_flag is high while the count equals rollover_val.
module flex_counter
  import rcv_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [WIDTH-1:0] rollover_val,
  output logic             rollover_flag
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count;

  assign rollover_flag = (count == rollover_val);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_enable) begin
      count <= rollover_flag ? ONE
                             : count + ONE;
    end
  end

endmodule

// File: rtl/rcv_ctrl.sv
// rcv_ctrl: UART receive sequencer for an external 9-bit shift register.
// Define RCV_GLITCH_FILTER_EN to add a 3-sample majority line filter.
module rcv_ctrl
  import rcv_pkg::*;
#(
  parameter int PERIOD_W = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                serial_in,
  input  logic [PERIOD_W-1:0] bit_period,
  input  logic [3:0]          data_size,
  input  logic                stop_bit,
  output logic                shift_strobe,
  output logic                load_buffer,
  output logic                framing_error,
  output logic                busy
);

  localparam logic [PERIOD_W-1:0] MIN_PERIOD =
    PERIOD_W'(2);

  rcv_state_t state;
  rcv_state_t state_nx;

  logic line;
  logic prev;
  logic start_edge;
  logic accept;
  logic last_bit;
  logic tmr_flag;
  logic tmr_en;
  logic tmr_clear;

  logic [3:0]          dsize_q;
  logic [3:0]          bit_cnt;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] tmr_roll;

`ifdef RCV_GLITCH_FILTER_EN
  logic [2:0] filt_sr;
  logic       filt;

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_sr <= 3'b111;
      filt    <= 1'b1;
    end else begin
      filt_sr <= {filt_sr[1:0], serial_in};
      filt    <= maj3(filt_sr);
    end
  end

  assign line = filt;
`else
  logic samp;

  always_ff @(posedge clk) begin
    if (rst) begin
      samp <= 1'b1;
    end else begin
      samp <= serial_in;
    end
  end

  assign line = samp;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= 1'b1;
    end else begin
      prev <= line;
    end
  end

  assign start_edge = (state == IDLE) &&
                      prev && !line;
  assign accept     = (state == START) &&
                      tmr_flag && !line;
  assign last_bit   = (bit_cnt == dsize_q);

  assign shift_strobe = (state == RECV) &&
                        tmr_flag;
  assign load_buffer  = (state == LOAD);
  assign busy         = (state != IDLE);

  // START times half a bit; its wrap to 1
  // doubles as the timer restart for RECV.
  assign tmr_roll  = (state == START) ?
                     (period_q >> 1) : period_q;
  assign tmr_en    = start_edge ||
                     (state == START) ||
                     (state == RECV);
  assign tmr_clear = !tmr_en;

  flex_counter #(
    .WIDTH (PERIOD_W)
  ) u_bit_tmr (
    .clk           (clk),
    .rst           (rst),
    .clear         (tmr_clear),
    .count_enable  (tmr_en),
    .rollover_val  (tmr_roll),
    .rollover_flag (tmr_flag)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start_edge) state_nx = START;
      end
      START: begin
        if (tmr_flag) begin
          state_nx = line ? IDLE : RECV;
        end
      end
      RECV: begin
        if (shift_strobe && last_bit) begin
          state_nx = STOP_CHK;
        end
      end
      STOP_CHK: begin
        state_nx = stop_bit ? LOAD : IDLE;
      end
      LOAD: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      dsize_q       <= DSIZE_8;
      period_q      <= MIN_PERIOD;
      framing_error <= 1'b0;
    end else begin
      state <= state_nx;
      if (start_edge) begin
        dsize_q  <= fix_dsize(data_size);
        period_q <= (bit_period < MIN_PERIOD) ?
                    MIN_PERIOD : bit_period;
      end
      if (accept) begin
        bit_cnt       <= '0;
        framing_error <= 1'b0;
      end else if (shift_strobe) begin
        bit_cnt <= bit_cnt + 4'd1;
      end
      if ((state == STOP_CHK) && !stop_bit) begin
        framing_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rcv_ctrl.sv
// tb_rcv_ctrl: scoreboard bench for rcv_ctrl with a modelled 9-bit
// receive shift register; honours RCV_GLITCH_FILTER_EN.
module tb_rcv_ctrl;

  localparam int PW = 14;
`ifdef RCV_GLITCH_FILTER_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] nbits;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          serial_in;
  logic [PW-1:0] bit_period;
  logic [3:0]    data_size;
  logic          stop_bit;
  logic          shift_strobe;
  logic          load_buffer;
  logic          framing_error;
  logic          busy;

  rcv_ctrl #(
    .PERIOD_W (PW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .serial_in     (serial_in),
    .bit_period    (bit_period),
    .data_size     (data_size),
    .stop_bit      (stop_bit),
    .shift_strobe  (shift_strobe),
    .load_buffer   (load_buffer),
    .framing_error (framing_error),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0] sr = 9'h1FF;
  always @(posedge clk) begin
    if (shift_strobe) sr <= {serial_in, sr[8:1]};
  end
  assign stop_bit = sr[8];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_strobe = 0;
  int   n_load   = 0;
  int   n_overlap = 0;
  int   n_busy_rise = 0;
  int   busy_rise_cyc = 0;
  logic fe_at_rise = 1'b0;
  logic busy_d = 1'b0;
  int         strobe_cyc[$];
  logic [8:0] rx_q[$];
  exp_t       exp_q[$];

  always @(negedge clk) begin
    if (shift_strobe) begin
      n_strobe <= n_strobe + 1;
      strobe_cyc.push_back(cyc);
    end
    if (load_buffer) begin
      n_load <= n_load + 1;
      rx_q.push_back(sr);
    end
    if (shift_strobe && load_buffer) begin
      n_overlap <= n_overlap + 1;
    end
    if (busy && !busy_d) begin
      n_busy_rise   <= n_busy_rise + 1;
      busy_rise_cyc <= cyc;
      fe_at_rise    <= framing_error;
    end
    busy_d <= busy;
  end

  task automatic send_frame(
    input  logic [7:0] data,
    input  int         nbits,
    input  logic       stop,
    input  int         lp,
    input  int         rst_after,
    output int         c0,
    output bit         aborted
  );
    int   seen;
    logic v;
    aborted = 1'b0;
    seen = 0;
    if (stop && rst_after == 0) begin
      exp_q.push_back('{data: data,
                        nbits: nbits[3:0]});
    end
    @(posedge clk); #1;
    c0 = cyc;
    for (int b = 0; b < nbits + 2; b++) begin
      if (b == 0) v = 1'b0;
      else if (b <= nbits) v = data[b-1];
      else v = stop;
      for (int k = 0; k < lp; k++) begin
        serial_in = v;
        @(posedge clk); #1;
        if (shift_strobe) seen++;
        if (rst_after != 0 && seen == rst_after) begin
          rst = 1'b1;
          aborted = 1'b1;
          break;
        end
      end
      if (aborted) break;
    end
    serial_in = 1'b1;
  endtask

  task automatic wait_idle(output bit to);
    int k;
    k = 0;
    while (busy && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    to = busy;
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    serial_in = 1'b1;
    bit_period = 14'd10;
    data_size = 4'd8;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (shift_strobe !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_strobe: got %b want 0", shift_strobe);
    end
    n_checks++;
    if (load_buffer !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_load: got %b want 0", load_buffer);
    end
    n_checks++;
    if (framing_error !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_fe: got %b want 0", framing_error);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_busy: got %b want 0", busy);
    end
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_frame(
    input string      nm,
    input logic [3:0] dsz,
    input logic [PW-1:0] bp,
    input int         lp,
    input int         nb,
    input logic [7:0] data
  );
    int c0, s0, l0, bad, first, exp_first;
    bit ab, to;
    logic [8:0] r;
    exp_t e;
    logic [7:0] got;
    data_size = dsz;
    bit_period = bp;
    s0 = n_strobe;
    l0 = n_load;
    strobe_cyc.delete();
    send_frame(data, nb, 1'b1, lp, 0, c0, ab);
    wait_idle(to);
    n_checks++;
    if (to) begin
      n_fail++;
      $display("FAIL %s_idle: busy=%b want 0", nm, busy);
    end
    n_checks++;
    if (n_strobe - s0 != nb + 1) begin
      n_fail++;
      $display("FAIL %s_strobes: got %0d want %0d",
               nm, n_strobe - s0, nb + 1);
    end
    exp_first = c0 + 1 + (lp / 2) + lp + LAT;
    first = (strobe_cyc.size() > 0) ?
            strobe_cyc[0] - 0 : -1;
    n_checks++;
    if (first != exp_first) begin
      n_fail++;
      $display("FAIL %s_first: cycle %0d want %0d",
               nm, first, exp_first);
    end
    bad = 0;
    for (int i = 1; i < strobe_cyc.size(); i++) begin
      if (strobe_cyc[i] - strobe_cyc[i-1] != lp) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s_gap: %0d bad gaps want 0", nm, bad);
    end
    n_checks++;
    if (n_load - l0 != 1) begin
      n_fail++;
      $display("FAIL %s_load: got %0d want 1", nm, n_load - l0);
    end
    n_checks++;
    if (framing_error !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_fe: got %b want 0", nm, framing_error);
    end
    n_checks++;
    if (rx_q.size() == 0 || exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_data: rx %0d exp %0d entries want both",
               nm, rx_q.size(), exp_q.size());
    end else begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      got = r[7:0] >> (4'd8 - e.nbits);
      if (got !== e.data || r[8] !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_data: got %h stop %b want %h stop 1",
                 nm, got, r[8], e.data);
      end
    end
  endtask

  task automatic test_framing_error();
    int c0, l0;
    bit ab, to;
    data_size = 4'd8;
    bit_period = 14'd10;
    l0 = n_load;
    send_frame(8'h5A, 8, 1'b0, 10, 0, c0, ab);
    wait_idle(to);
    n_checks++;
    if (to || n_load != l0) begin
      n_fail++;
      $display("FAIL ferr_noload: loads %0d busy %b want 0 0",
               n_load - l0, busy);
    end
    n_checks++;
    if (framing_error !== 1'b1) begin
      n_fail++;
      $display("FAIL ferr_set: got %b want 1", framing_error);
    end
    test_frame("ferr_clear", 4'd8, 14'd10, 10, 8, 8'h81);
    n_checks++;
    if (fe_at_rise !== 1'b1) begin
      n_fail++;
      $display("FAIL ferr_hold: fe at start %b want 1", fe_at_rise);
    end
  endtask

  task automatic test_glitch();
    int c0, s0, b0;
    bit to;
    bit_period = 14'd10;
    s0 = n_strobe;
    b0 = n_busy_rise;
    @(posedge clk); #1;
    c0 = cyc;
    serial_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    serial_in = 1'b1;
    while (cyc < c0 + 6 + LAT) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_start: busy %b want 1", busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_idle: busy %b want 0", busy);
    end
    wait_idle(to);
    n_checks++;
    if (n_strobe != s0 || n_busy_rise != b0 + 1) begin
      n_fail++;
      $display("FAIL glitch_pulses: strobes %0d starts %0d want 0 1",
               n_strobe - s0, n_busy_rise - b0);
    end
  endtask

  task automatic test_reset_midframe();
    int c0, l0;
    bit ab;
    data_size = 4'd8;
    bit_period = 14'd10;
    l0 = n_load;
    send_frame(8'hC3, 8, 1'b1, 10, 4, c0, ab);
    n_checks++;
    if (!ab) begin
      n_fail++;
      $display("FAIL midrst_abort: reached %b want 1", ab);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({shift_strobe, load_buffer, framing_error, busy}
        !== 4'b0000) begin
      n_fail++;
      $display("FAIL midrst_outs: got %b%b%b%b want 0000",
               shift_strobe, load_buffer, framing_error, busy);
    end
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (n_load != l0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_quiet: loads %0d busy %b want 0 0",
               n_load - l0, busy);
    end
    test_frame("after_rst", 4'd8, 14'd10, 10, 8, 8'h3C);
  endtask

`ifdef RCV_GLITCH_FILTER_EN
  task automatic test_filter_pulse();
    int b0;
    b0 = n_busy_rise;
    @(posedge clk); #1;
    serial_in = 1'b0;
    @(posedge clk); #1;
    serial_in = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (n_busy_rise != b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL filt_pulse: starts %0d busy %b want 0 0",
               n_busy_rise - b0, busy);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t want finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame("frame8", 4'd8, 14'd10, 10, 8, 8'hA5);
    n_checks++;
    if (busy_rise_cyc != strobe_cyc[0] - 14) begin
      n_fail++;
      $display("FAIL frame8_start: busy at %0d want %0d",
               busy_rise_cyc, strobe_cyc[0] - 14);
    end
    test_frame("frame5", 4'd5, 14'd10, 10, 5, 8'h13);
    test_framing_error();
    test_glitch();
    test_frame("dsize6_p0", 4'd6, 14'd0, 2, 8, 8'hFF);
    test_frame("frame7", 4'd7, 14'd8, 8, 7, 8'h55);
    test_reset_midframe();
`ifdef RCV_GLITCH_FILTER_EN
    test_filter_pulse();
`endif
    n_checks++;
    if (n_overlap != 0) begin
      n_fail++;
      $display("FAIL overlap: %0d cycles want 0", n_overlap);
    end
    n_checks++;
    if (rx_q.size() != 0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: rx %0d exp %0d want 0 0",
               rx_q.size(), exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
